// File: rtl/imem_pkg.sv
// Shared sizing and state encoding for the instruction-memory loader.
package imem_pkg;
  localparam int IMEM_DEPTH = 64;
  localparam int IMEM_AW    = 6;
  localparam int IMEM_DW    = 32;
  localparam int IMEM_CW    = IMEM_AW + 1;

  localparam logic [IMEM_AW-1:0] LAST_ADDR = IMEM_AW'(IMEM_DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } ld_state_t;
endpackage

// File: rtl/imem_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; a short final word is zero padded.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_push,
  input  logic               i_last,
  input  logic [7:0]         i_byte,
  output logic               o_word_done,
  output logic [IMEM_DW-1:0] o_word
);
  logic [1:0]         r_idx;
  logic [23:0]        r_bytes;
  logic [IMEM_DW-1:0] w_cur;

  // Held bytes above the current index are always zero, so OR-merging the
  // incoming byte gives the assembled word including the padding.
  assign w_cur       = {24'h000000, i_byte} << {r_idx, 3'b000};
  assign o_word      = {8'h00, r_bytes} | w_cur;
  assign o_word_done = i_push & (i_last | (r_idx == 2'd3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= 2'd0;
      r_bytes <= 24'h000000;
    end else if (i_clr || o_word_done) begin
      r_idx   <= 2'd0;
      r_bytes <= 24'h000000;
    end else if (i_push) begin
      r_idx   <= r_idx + 2'd1;
      r_bytes <= o_word[23:0];
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Streams a byte program into instruction memory, zero-fills the tail and
// holds the CPU in reset until the image is complete.
module imem_loader
  import imem_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  input  logic                byte_last,
  output logic                byte_ready,
  output logic                wr_en,
  output logic [IMEM_AW-1:0]  wr_addr,
  output logic [IMEM_DW-1:0]  wr_data,
  output logic [IMEM_CW-1:0]  word_count,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                cpu_reset
);
  ld_state_t          r_state;
  logic [IMEM_AW-1:0] r_addr;
  logic               r_wr_en;
  logic [IMEM_AW-1:0] r_wr_addr;
  logic [IMEM_DW-1:0] r_wr_data;
  logic [IMEM_CW-1:0] r_word_count;

  logic               w_push;
  logic               w_word_done;
  logic [IMEM_DW-1:0] w_word;
  logic               w_pk_clr;

  assign byte_ready = (r_state == ST_LOAD);
  assign w_push     = byte_valid & byte_ready;
  assign w_pk_clr   = (r_state != ST_LOAD);

  imem_word_packer u_packer (
    .clk         (clk),
    .rst         (reset),
    .i_clr       (w_pk_clr),
    .i_push      (w_push),
    .i_last      (byte_last),
    .i_byte      (byte_data),
    .o_word_done (w_word_done),
    .o_word      (w_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_word_count <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_state      <= ST_LOAD;
            r_addr       <= '0;
            r_word_count <= '0;
          end
        end
        ST_LOAD: begin
          if (w_word_done) begin
            r_wr_en      <= 1'b1;
            r_wr_addr    <= r_addr;
            r_wr_data    <= w_word;
            r_word_count <= r_word_count + 1'b1;
            r_addr       <= r_addr + 1'b1;
            if (byte_last)
              r_state <= (r_addr == LAST_ADDR) ? ST_DONE : ST_CLEAR;
            else if (r_addr == LAST_ADDR)
              r_state <= ST_ERR;
          end
        end
        ST_CLEAR: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_addr;
          r_wr_data <= '0;
          r_addr    <= r_addr + 1'b1;
          if (r_addr == LAST_ADDR)
            r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign word_count = r_word_count;
  assign busy       = (r_state == ST_LOAD) || (r_state == ST_CLEAR);
  assign done       = (r_state == ST_DONE);
  assign err        = (r_state == ST_ERR);
  assign cpu_reset  = (r_state != ST_DONE);
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: logs every write strobe and checks it against hand-built images.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset, start, byte_valid, byte_last;
  logic [7:0]  byte_data;
  logic        byte_ready, wr_en, busy, done, err, cpu_reset;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [6:0]  word_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [5:0]  la[$];
  logic [31:0] ld[$];
  int          lc[$];
  logic [31:0] exp_w[$];
  logic [7:0]  prog[$];

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .word_count(word_count),
    .busy(busy), .done(done), .err(err), .cpu_reset(cpu_reset)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      la.push_back(wr_addr);
      ld.push_back(wr_data);
      lc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_log();
    la.delete(); ld.delete(); lc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    byte_valid = 1'b1; byte_data = b; byte_last = last;
    while (!byte_ready && n < 20) begin tick(); n++; end
    if (n == 20) chk("ready_timeout", 32'd0, 32'd1);
    tick();
    byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic send_prog(input bit gaps);
    for (int i = 0; i < prog.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          start = 1'($urandom_range(0, 1));
          tick();
          start = 1'b0;
        end
      end
      push(prog[i], i == prog.size() - 1);
    end
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!done && !err && n < 200) begin tick(); n++; end
    if (n == 200) chk("end_timeout", 32'd0, 32'd1);
    tick();
  endtask

  // Image check: nw program words then zero fill to address 63 on consecutive cycles.
  task automatic check_image(input int nw);
    chk("nwrites", la.size(), 64);
    for (int k = 0; k < 64 && k < la.size(); k++) begin
      chk($sformatf("addr%0d", k), la[k], k);
      chk($sformatf("data%0d", k), ld[k], (k < nw) ? exp_w[k] : 32'h0);
    end
    if (la.size() == 64 && nw < 64) chk("clear_span", lc[63] - lc[nw], 63 - nw);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_flags"}, {26'd0, byte_ready, wr_en, busy, done, err, cpu_reset}, 32'h1);
    chk({tag, "_addr"}, wr_addr, 32'd0);
    chk({tag, "_data"}, wr_data, 32'd0);
    chk({tag, "_wc"}, word_count, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; byte_data = 8'h00;
    tick(); tick();
    check_reset_vals("por");
    reset = 1'b0;
    tick();

    // Two full words with byte_last on the 8th byte.
    clr_log();
    pulse_start();
    chk("load_busy", {29'd0, busy, byte_ready, done}, 32'b110);
    prog = '{8'he0, 8'h03, 8'h1f, 8'h8b, 8'h01, 8'h00, 8'h1f, 8'h8b};
    exp_w = '{32'h8b1f03e0, 32'h8b1f0001};
    send_prog(1'b0);
    wait_end();
    check_image(2);
    chk("a_status", {29'd0, done, cpu_reset, err}, 32'b100);
    chk("a_wc", word_count, 32'd2);

    // Partial final word, restarted from DONE.
    clr_log();
    pulse_start();
    chk("b_enter", {25'd0, word_count}, 32'd0);
    chk("b_done_clr", {30'd0, done, cpu_reset}, 32'b01);
    prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_w = '{32'h44332211, 32'h00000055};
    send_prog(1'b0);
    wait_end();
    check_image(2);
    chk("b_wc", word_count, 32'd2);

    // 256-byte full image: one write every 4 cycles, no clear.
    clr_log();
    pulse_start();
    prog.delete(); exp_w.delete();
    for (int i = 0; i < 256; i++) prog.push_back(8'(i));
    for (int j = 0; j < 64; j++)
      exp_w.push_back({8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)});
    send_prog(1'b0);
    wait_end();
    check_image(64);
    for (int j = 1; j < 64 && j < lc.size(); j++)
      chk($sformatf("c_gap%0d", j), lc[j] - lc[j-1], 32'd4);
    chk("c_status", {29'd0, done, err, cpu_reset}, 32'b100);
    chk("c_wc", word_count, 32'd64);

    // Overflow: 256 bytes without last, then a 257th is refused.
    clr_log();
    pulse_start();
    for (int i = 0; i < 256; i++) push(8'(i), 1'b0);
    byte_valid = 1'b1; byte_data = 8'hff;
    tick(); tick(); tick();
    byte_valid = 1'b0;
    chk("d_nwrites", la.size(), 64);
    if (la.size() > 0) chk("d_lastaddr", la[la.size()-1], 32'd63);
    chk("d_status", {27'd0, err, byte_ready, cpu_reset, done, busy}, 32'b10100);
    chk("d_wc", word_count, 32'd64);

    // Reset in the middle of the clear sweep, then a fresh 4-byte load.
    clr_log();
    pulse_start();
    prog = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_prog(1'b0);
    begin
      int n;
      n = 0;
      while (!(wr_en && wr_addr == 6'd20) && n < 100) begin tick(); n++; end
      chk("e_reach20", {31'd0, busy}, 32'd1);
    end
    reset = 1'b1;
    #1;
    check_reset_vals("mid_clear");
    tick();
    reset = 1'b0;
    clr_log();
    tick(); tick(); tick();
    chk("e_no_strobe", la.size(), 32'd0);
    check_reset_vals("post_rst");
    pulse_start();
    prog = '{8'haa, 8'hbb, 8'hcc, 8'hdd};
    exp_w = '{32'hddccbbaa};
    send_prog(1'b0);
    wait_end();
    check_image(1);
    chk("e_wc", word_count, 32'd1);

    // Gapped stream with start pulses in LOAD and CLEAR gives the same image.
    clr_log();
    pulse_start();
    prog = '{8'he0, 8'h03, 8'h1f, 8'h8b, 8'h01, 8'h00, 8'h1f, 8'h8b};
    exp_w = '{32'h8b1f03e0, 32'h8b1f0001};
    send_prog(1'b1);
    pulse_start();
    tick();
    pulse_start();
    wait_end();
    check_image(2);
    chk("f_wc", word_count, 32'd2);
    chk("f_done", {31'd0, done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk is the sole clock; reset asynchronously forces every register to its reset value while high.
REQ-002 Ports SHALL be:
- clk  in  1  system clock, rising edge
- reset  in  1  async active-high reset
- start  in  1  begin a load session
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  program byte
- byte_last  in  1  qualifies final byte of program
- byte_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  instruction-memory write strobe
- wr_addr  out  6  word address (0..63)
- wr_data  out  32  instruction word
- word_count  out  7  stream words written (0..64)
- busy  out  1  session in progress
- done  out  1  program loaded, memory consistent
- err  out  1  overflow: program longer than 64 words
- cpu_reset  out  1  hold processor in reset until done

Function
REQ-003 A byte transfer SHALL occur exactly on a cycle with byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 only in state LOAD, decoded from state, with no dependence on byte_valid.
REQ-004 States SHALL be IDLE, LOAD, CLEAR, DONE, ERR.
REQ-005 IDLE->LOAD on start=1; DONE->LOAD and ERR->LOAD on start=1; start SHALL be ignored in LOAD and CLEAR.
REQ-006 Entering LOAD SHALL zero the word address, byte index, word_count, done, and err.
REQ-007 Bytes SHALL pack little-endian: first byte of a word -> wr_data[7:0], fourth -> [31:24].
REQ-008 On the fourth byte transfer, or on a byte_last transfer, the block SHALL assert wr_en for exactly one cycle in the next cycle, with wr_addr = current word address, and SHALL increment word_count in that same cycle.
REQ-009 A byte_last on byte 1-3 of a word SHALL write that word with unreceived upper bytes as 0x00.
REQ-010 After the byte_last write: if wr_addr was 63 -> DONE; else -> CLEAR.
REQ-011 CLEAR SHALL write 32'h00000000 to each remaining address, one per cycle, ascending, wr_en=1 every CLEAR cycle; after writing address 63 -> DONE. CLEAR SHALL NOT change word_count.
REQ-012 If the 64th word is written without byte_last, the state SHALL go to ERR and err SHALL be 1; no further bytes SHALL be accepted (byte_ready=0).
REQ-013 busy SHALL be 1 in LOAD and CLEAR, else 0; done SHALL be 1 only in DONE; cpu_reset SHALL be 0 only in DONE.
REQ-014 wr_addr and wr_data SHALL hold their last values when wr_en=0.
REQ-015 Burst throughput SHALL be one byte per cycle in LOAD, with no bubble at word boundaries.

Reset
REQ-016 Reset values: state IDLE, byte_ready 0, wr_en 0, wr_addr 0, wr_data 0, word_count 0, busy 0, done 0, err 0, cpu_reset 1.
REQ-017 Reset mid-LOAD or mid-CLEAR SHALL abandon the session immediately with no write strobe on the cycle reset deasserts; partially assembled bytes SHALL be discarded.

Structure
REQ-018 Package imem_pkg SHALL hold IMEM_DEPTH=64, IMEM_AW=6, the word width 32, and the loader state enum.
REQ-019 Byte-to-word assembly (byte index, shift register, zero padding) SHALL be a sub-module imem_word_packer; the FSM, address counter and clear sequencing SHALL stay in imem_loader.

Verification
REQ-020 Load 8 bytes e0 03 1f 8b 01 00 1f 8b with byte_last on the 8th -> writes 0x8b1f03e0 @0 and 0x8b1f0001 @1, then zero writes @2..63 on 62 consecutive cycles, done=1, word_count=2, cpu_reset=0.
REQ-021 Load 5 bytes 11 22 33 44 55, byte_last on 55 -> writes 0x44332211 @0 and 0x00000055 @1, CLEAR @2..63, word_count=2.
REQ-022 Stream 256 bytes, byte_last on byte 256, byte_valid held high -> 64 writes, one every 4 cycles, no CLEAR, DONE, word_count=64, err=0.
REQ-023 Stream 257 bytes with no byte_last -> ERR after 64th write, err=1, byte_ready=0, cpu_reset=1, no write to any address after 63.
REQ-024 Assert reset during CLEAR at wr_addr=20 -> all outputs at reset values next cycle; a following start plus 4-byte load with byte_last writes @0 and clears @1..63.
REQ-025 Toggle byte_valid randomly and pulse start during LOAD -> write data and addresses identical to the gap-free run; start ignored.
